// File: rtl/wb_spi_ctrl_pkg.sv
// Shared definitions for the Wishbone SPI controller: register map,
// CTRL/STATUS bit layout and master FSM states.
package wb_spi_ctrl_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int unsigned CTRL_PRESC_LSB   = 0;
  localparam int unsigned CTRL_SIZE_LSB    = 4;
  localparam int unsigned CTRL_CPOL_BIT    = 6;
  localparam int unsigned CTRL_AUTO_CS_BIT = 7;

  localparam int unsigned ST_RDY_BIT      = 0;
  localparam int unsigned ST_EMPTY_BIT    = 1;
  localparam int unsigned ST_FULL_BIT     = 2;
  localparam int unsigned ST_RX_VALID_BIT = 3;
  localparam int unsigned ST_OVF_BIT      = 4;
  localparam int unsigned ST_LEVEL_LSB    = 5;

  localparam logic [7:0] CTRL_RST = 8'h81;

  typedef enum logic [2:0] {IDLE, WR, SETTLE, WAIT, RD} state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous TX word FIFO; callers must not push when full or pop when empty.
module spi_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/wb_spi_ctrl.sv
// CPU-facing register block and TX queue that drives the wb_spi engine
// through a Wishbone master port and captures each RX word.
module wb_spi_ctrl
  import wb_spi_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [1:0]  s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        spi_rdy_i,
  output logic [3:0]  presc_o,
  output logic [1:0]  size_o,
  output logic        cpol_o,
  output logic        auto_cs_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  state_t        state, state_next;
  logic [7:0]    ctrl;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          ovf;
  logic [31:0]   fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic          access, ctrl_blocked, grant, wr_grant, rd_grant;
  logic [31:0]   status, rd_mux;

  spi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (s_dat_i),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A CTRL write stalls (no ack) until the engine is quiescent, so the
  // configuration outputs can never change under a queued or live transfer.
  assign access       = s_cyc_i & s_stb_i & ~s_ack_o;
  assign ctrl_blocked = s_we_i && (s_adr_i == REG_CTRL) && ((state != IDLE) || !fifo_empty);
  assign grant        = access & ~ctrl_blocked;
  assign wr_grant     = grant & s_we_i;
  assign rd_grant     = grant & ~s_we_i;
  assign push         = wr_grant && (s_adr_i == REG_TXDATA) && !fifo_full;

  always_comb begin
    status = '0;
    status[ST_RDY_BIT]             = spi_rdy_i;
    status[ST_EMPTY_BIT]           = fifo_empty;
    status[ST_FULL_BIT]            = fifo_full;
    status[ST_RX_VALID_BIT]        = rx_valid;
    status[ST_OVF_BIT]             = ovf;
    status[ST_LEVEL_LSB +: LW]     = fifo_level;
  end

  always_comb begin
    rd_mux = '0;
    case (s_adr_i)
      REG_CTRL:   rd_mux = {24'd0, ctrl};
      REG_STATUS: rd_mux = status;
      REG_RXDATA: rd_mux = rx_data;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl     <= CTRL_RST;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ovf      <= 1'b0;
      s_ack_o  <= 1'b0;
      s_dat_o  <= '0;
    end else begin
      s_ack_o <= grant;
      s_dat_o <= rd_grant ? rd_mux : '0;
      if (wr_grant && (s_adr_i == REG_CTRL))   ctrl <= s_dat_i[7:0];
      if (wr_grant && (s_adr_i == REG_STATUS)) ovf  <= 1'b0;
      if (wr_grant && (s_adr_i == REG_TXDATA) && fifo_full) ovf <= 1'b1;
      if (rd_grant && (s_adr_i == REG_RXDATA)) rx_valid <= 1'b0;
      // Later assignment wins: a fresh RX word beats a same-cycle clear.
      if ((state == RD) && m_ack_i) begin
        rx_data  <= m_dat_i;
        rx_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    m_cyc_o    = 1'b0;
    m_stb_o    = 1'b0;
    m_we_o     = 1'b0;
    m_dat_o    = '0;
    pop        = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && spi_rdy_i) state_next = WR;
      WR: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
        m_dat_o = fifo_head;
        if (m_ack_i) begin
          pop        = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: state_next = WAIT;
      WAIT:   if (spi_rdy_i) state_next = RD;
      RD: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
        if (m_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign presc_o   = ctrl[CTRL_PRESC_LSB +: 4];
  assign size_o    = ctrl[CTRL_SIZE_LSB +: 2];
  assign cpol_o    = ctrl[CTRL_CPOL_BIT];
  assign auto_cs_o = ctrl[CTRL_AUTO_CS_BIT];

endmodule
